// File: rtl/tetris_step_sched_if.sv
// Handshake bundle between the step scheduler and its piece generator,
// collision checker and board-lock engine.
interface tetris_step_sched_if;
  logic       gen_enable;
  logic       gen_done;
  logic [4:0] gen_pos_i;
  logic [4:0] gen_pos_j;
  logic [2:0] gen_type;

  logic       chk_req;
  logic [4:0] chk_pos_i;
  logic [4:0] chk_pos_j;
  logic [1:0] chk_rot;
  logic [2:0] chk_type;
  logic       chk_ack;
  logic       chk_ok;

  logic       lock_req;
  logic       lock_ack;

  modport master (
    output gen_enable,
    input  gen_done, gen_pos_i, gen_pos_j, gen_type,
    output chk_req, chk_pos_i, chk_pos_j, chk_rot, chk_type,
    input  chk_ack, chk_ok,
    output lock_req,
    input  lock_ack
  );

  modport slave (
    input  gen_enable,
    output gen_done, gen_pos_i, gen_pos_j, gen_type,
    input  chk_req, chk_pos_i, chk_pos_j, chk_rot, chk_type,
    output chk_ack, chk_ok,
    input  lock_req,
    output lock_ack
  );
endinterface

// File: rtl/tetris_step_sched.sv
// Active-piece step scheduler: spawns, moves, rotates and locks the falling piece.
// Optional macro TETRIS_HARD_DROP_EN turns a served drop into repeated down steps.
//
// state     | meaning
// IDLE      | no game, waiting for start
// SPAWN     | gen_enable high, waiting for gen_done
// SPAWN_CHK | checking the freshly generated piece
// READY     | piece committed, serving one pending request per visit
// MOVE_CHK  | checking a move/rotate candidate
// LOCK      | lock_req high, waiting for lock_ack
// OVER      | spawn blocked, game_over held
module tetris_step_sched (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       gravity_tick,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_rot,
  input  logic                       btn_drop,
  tetris_step_sched_if.master        bus,
  output logic [4:0]                 cur_pos_i,
  output logic [4:0]                 cur_pos_j,
  output logic [1:0]                 cur_rot,
  output logic [2:0]                 cur_type,
  output logic                       piece_valid,
  output logic                       game_over,
  output logic                       busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SPAWN     = 3'd1;
  localparam logic [2:0] SPAWN_CHK = 3'd2;
  localparam logic [2:0] READY     = 3'd3;
  localparam logic [2:0] MOVE_CHK  = 3'd4;
  localparam logic [2:0] LOCK      = 3'd5;
  localparam logic [2:0] OVER      = 3'd6;

  // pending / pick bit order: {drop, gravity, rot, left, right}
  logic [2:0] state;
  logic [4:0] pend;
  logic [4:0] pick;
  logic [4:0] pend_set;
  logic [4:0] pend_clr;
  logic       enter_spawn;
  logic       chk_req_q;
  logic       mv_down;
  logic [4:0] cand_i;
  logic [4:0] cand_j;
  logic [1:0] cand_rot;
  logic [2:0] cand_type;
`ifdef TETRIS_HARD_DROP_EN
  logic       mv_drop;
`endif

  assign bus.gen_enable = (state == SPAWN);
  assign bus.lock_req   = (state == LOCK);
  assign bus.chk_req    = chk_req_q;
  assign bus.chk_pos_i  = cand_i;
  assign bus.chk_pos_j  = cand_j;
  assign bus.chk_rot    = cand_rot;
  assign bus.chk_type   = cand_type;
  assign busy = (state != READY) && (state != IDLE) && (state != OVER);

  assign enter_spawn = (((state == IDLE) || (state == OVER)) && start) ||
                       ((state == LOCK) && bus.lock_ack);
  assign pend_set = ((state != IDLE) && (state != OVER)) ?
                    {btn_drop, gravity_tick, btn_rot, btn_left, btn_right} : 5'd0;

  always_comb begin
    pick = 5'd0;
    if (state == READY) begin
      if      (pend[4]) pick[4] = 1'b1;
      else if (pend[3]) pick[3] = 1'b1;
      else if (pend[2]) pick[2] = 1'b1;
      else if (pend[1]) pick[1] = 1'b1;
      else if (pend[0]) pick[0] = 1'b1;
    end
    pend_clr = enter_spawn ? 5'h1f : pick;
  end

  // a new pulse always survives a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= 5'd0;
    else        pend <= (pend & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      chk_req_q   <= 1'b0;
      mv_down     <= 1'b0;
      cand_i      <= 5'd0;
      cand_j      <= 5'd0;
      cand_rot    <= 2'd0;
      cand_type   <= 3'd0;
      cur_pos_i   <= 5'd0;
      cur_pos_j   <= 5'd0;
      cur_rot     <= 2'd0;
      cur_type    <= 3'd0;
      piece_valid <= 1'b0;
      game_over   <= 1'b0;
`ifdef TETRIS_HARD_DROP_EN
      mv_drop     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state     <= SPAWN;
            game_over <= 1'b0;
          end
        end
        SPAWN: begin
          if (bus.gen_done) begin
            cand_i    <= bus.gen_pos_i;
            cand_j    <= bus.gen_pos_j;
            cand_type <= bus.gen_type;
            cand_rot  <= 2'd0;
            chk_req_q <= 1'b1;
            state     <= SPAWN_CHK;
          end
        end
        SPAWN_CHK: begin
          if (chk_req_q && bus.chk_ack) begin
            chk_req_q <= 1'b0;
            if (bus.chk_ok) begin
              cur_pos_i   <= cand_i;
              cur_pos_j   <= cand_j;
              cur_rot     <= cand_rot;
              cur_type    <= cand_type;
              piece_valid <= 1'b1;
              state       <= READY;
            end else begin
              piece_valid <= 1'b0;
              game_over   <= 1'b1;
              state       <= OVER;
            end
          end
        end
        READY: begin
          // candidate defaults to the committed piece; the served request overrides one field
          cand_i    <= cur_pos_i;
          cand_j    <= cur_pos_j;
          cand_rot  <= cur_rot;
          cand_type <= cur_type;
          mv_down   <= 1'b0;
          if (pick[4] || pick[3]) begin
            if (cur_pos_i == 5'd31) begin
              state <= LOCK;
            end else begin
              cand_i    <= cur_pos_i + 5'd1;
              mv_down   <= 1'b1;
              chk_req_q <= 1'b1;
              state     <= MOVE_CHK;
            end
`ifdef TETRIS_HARD_DROP_EN
            mv_drop <= pick[4];
`endif
          end else if (pick[2]) begin
            cand_rot  <= cur_rot + 2'd1;
            chk_req_q <= 1'b1;
            state     <= MOVE_CHK;
          end else if (pick[1] && (cur_pos_j != 5'd0)) begin
            cand_j    <= cur_pos_j - 5'd1;
            chk_req_q <= 1'b1;
            state     <= MOVE_CHK;
          end else if (pick[0] && (cur_pos_j != 5'd31)) begin
            cand_j    <= cur_pos_j + 5'd1;
            chk_req_q <= 1'b1;
            state     <= MOVE_CHK;
          end
        end
        MOVE_CHK: begin
          if (!chk_req_q) begin
            chk_req_q <= 1'b1;
          end else if (bus.chk_ack) begin
            chk_req_q <= 1'b0;
            if (bus.chk_ok) begin
              cur_pos_i <= cand_i;
              cur_pos_j <= cand_j;
              cur_rot   <= cand_rot;
              cur_type  <= cand_type;
              state     <= READY;
`ifdef TETRIS_HARD_DROP_EN
              // keep falling: one idle cycle of chk_req, then the next row
              if (mv_drop) begin
                if (cand_i == 5'd31) state <= LOCK;
                else begin
                  cand_i <= cand_i + 5'd1;
                  state  <= MOVE_CHK;
                end
              end
`endif
            end else begin
              state <= mv_down ? LOCK : READY;
            end
          end
        end
        LOCK: begin
          if (bus.lock_ack) begin
            piece_valid <= 1'b0;
            state       <= SPAWN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_step_sched.sv
// Self-checking bench for tetris_step_sched: directed scenarios plus a randomized
// move sequence checked against a piece-position model kept in the bench.
module tb_tetris_step_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, gravity_tick = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_rot = 1'b0, btn_drop = 1'b0;
  logic [4:0] cur_pos_i, cur_pos_j;
  logic [1:0] cur_rot;
  logic [2:0] cur_type;
  logic piece_valid, game_over, busy;

  tetris_step_sched_if bus_if ();

  tetris_step_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gravity_tick(gravity_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_drop(btn_drop),
    .bus(bus_if),
    .cur_pos_i(cur_pos_i), .cur_pos_j(cur_pos_j), .cur_rot(cur_rot), .cur_type(cur_type),
    .piece_valid(piece_valid), .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // model of the committed piece
  int m_i, m_j, m_rot, m_type;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic pulse(input int a);
    case (a)
      0: btn_drop = 1'b1;
      1: gravity_tick = 1'b1;
      2: btn_rot = 1'b1;
      3: btn_left = 1'b1;
      default: btn_right = 1'b1;
    endcase
    @(negedge clk);
    btn_drop = 1'b0; gravity_tick = 1'b0; btn_rot = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
  endtask

  task automatic wait_for(input int which, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((which == 0 && bus_if.gen_enable) || (which == 1 && bus_if.chk_req) ||
          (which == 2 && bus_if.lock_req)) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack_chk(input bit ok);
    bus_if.chk_ack = 1'b1; bus_if.chk_ok = ok;
    @(negedge clk);
    bus_if.chk_ack = 1'b0; bus_if.chk_ok = 1'b0;
  endtask

  task automatic ack_lock();
    bus_if.lock_ack = 1'b1;
    @(negedge clk);
    bus_if.lock_ack = 1'b0;
  endtask

  task automatic give_gen(input int gi, input int gj, input int gt);
    bus_if.gen_done = 1'b1;
    bus_if.gen_pos_i = 5'(gi); bus_if.gen_pos_j = 5'(gj); bus_if.gen_type = 3'(gt);
    @(negedge clk);
    bus_if.gen_done = 1'b0;
  endtask

  task automatic test_reset();
    bit bad;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cur_pos_i, cur_pos_j, cur_rot, cur_type} !== 15'd0) begin
      errors++; $display("FAIL reset_cur: got %h %h %h %h, want all 0", cur_pos_i, cur_pos_j, cur_rot, cur_type);
    end
    checks++;
    if ({piece_valid, game_over, busy, bus_if.gen_enable, bus_if.chk_req, bus_if.lock_req} !== 6'd0) begin
      errors++; $display("FAIL reset_flags: got pv=%b go=%b busy=%b gen=%b chk=%b lock=%b, want 0",
                         piece_valid, game_over, busy, bus_if.gen_enable, bus_if.chk_req, bus_if.lock_req);
    end
    rst_n = 1'b1;
    bus_if.gen_done = 1'b1; bus_if.chk_ack = 1'b1; bus_if.lock_ack = 1'b1; gravity_tick = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy || bus_if.gen_enable || bus_if.chk_req || bus_if.lock_req || piece_valid) bad = 1'b1;
    end
    bus_if.gen_done = 1'b0; bus_if.chk_ack = 1'b0; bus_if.lock_ack = 1'b0; gravity_tick = 1'b0;
    checks++;
    if (bad) begin errors++; $display("FAIL idle_ignores_inputs: activity seen in IDLE, want none"); end
  endtask

  task automatic test_spawn();
    int hi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hi = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus_if.gen_enable) hi++;
      @(negedge clk);
    end
    if (bus_if.gen_enable) hi++;
    checks++;
    if (hi != 4) begin errors++; $display("FAIL spawn_gen_hold: gen_enable high %0d of 4 cycles, want 4", hi); end
    give_gen(0, 4, 5);
    checks++;
    if (bus_if.gen_enable !== 1'b0 || bus_if.chk_req !== 1'b1) begin
      errors++; $display("FAIL spawn_after_done: gen=%b chk=%b, want gen=0 chk=1", bus_if.gen_enable, bus_if.chk_req);
    end
    checks++;
    if ({bus_if.chk_pos_i, bus_if.chk_pos_j, bus_if.chk_rot, bus_if.chk_type} !== {5'd0, 5'd4, 2'd0, 3'd5}) begin
      errors++; $display("FAIL spawn_payload: got %0d,%0d r%0d t%0d, want 0,4 r0 t5",
                         bus_if.chk_pos_i, bus_if.chk_pos_j, bus_if.chk_rot, bus_if.chk_type);
    end
    ack_chk(1'b1);
    m_i = 0; m_j = 4; m_rot = 0; m_type = 5;
    checks++;
    if ({cur_pos_i, cur_pos_j, cur_rot, cur_type, piece_valid, busy, bus_if.chk_req} !==
        {5'd0, 5'd4, 2'd0, 3'd5, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL spawn_commit: got %0d,%0d r%0d t%0d pv=%b busy=%b chk=%b, want 0,4 r0 t5 pv=1 busy=0 chk=0",
                         cur_pos_i, cur_pos_j, cur_rot, cur_type, piece_valid, busy, bus_if.chk_req);
    end
  endtask

  task automatic test_priority();
    bit seen;
    pulse(2);
    wait_for(1, seen);
    checks++;
    if (!seen || bus_if.chk_rot !== 2'(m_rot + 1)) begin
      errors++; $display("FAIL prio_rot: seen=%b rot=%0d, want seen=1 rot=%0d", seen, bus_if.chk_rot, (m_rot + 1) % 4);
    end
    gravity_tick = 1'b1; btn_left = 1'b1;
    @(negedge clk);
    gravity_tick = 1'b0; btn_left = 1'b0;
    ack_chk(1'b1);
    m_rot = (m_rot + 1) % 4;
    wait_for(1, seen);
    checks++;
    if (!seen || bus_if.chk_pos_i !== 5'(m_i + 1) || bus_if.chk_pos_j !== 5'(m_j)) begin
      errors++; $display("FAIL prio_gravity_first: got %0d,%0d, want %0d,%0d", bus_if.chk_pos_i, bus_if.chk_pos_j, m_i + 1, m_j);
    end
    ack_chk(1'b1);
    m_i++;
    wait_for(1, seen);
    checks++;
    if (!seen || bus_if.chk_pos_i !== 5'(m_i) || bus_if.chk_pos_j !== 5'(m_j - 1)) begin
      errors++; $display("FAIL prio_left_second: got %0d,%0d, want %0d,%0d", bus_if.chk_pos_i, bus_if.chk_pos_j, m_i, m_j - 1);
    end
    ack_chk(1'b1);
    m_j--;
    checks++;
    if ({cur_pos_i, cur_pos_j, cur_rot} !== {5'(m_i), 5'(m_j), 2'(m_rot)}) begin
      errors++; $display("FAIL prio_commit: got %0d,%0d r%0d, want %0d,%0d r%0d", cur_pos_i, cur_pos_j, cur_rot, m_i, m_j, m_rot);
    end
  endtask

  task automatic test_left_edge();
    bit seen, bad;
    int hold;
    while (m_j > 0) begin
      pulse(3);
      wait_for(1, seen);
      checks++;
      if (!seen || bus_if.chk_pos_j !== 5'(m_j - 1)) begin
        errors++; $display("FAIL edge_walk_left: seen=%b j=%0d, want j=%0d", seen, bus_if.chk_pos_j, m_j - 1);
      end
      ack_chk(1'b1);
      m_j--;
    end
    pulse(3);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus_if.chk_req || busy) bad = 1'b1;
    end
    checks++;
    if (bad || cur_pos_j !== 5'd0) begin
      errors++; $display("FAIL edge_left_discard: activity=%b j=%0d, want activity=0 j=0", bad, cur_pos_j);
    end
    pulse(1);
    wait_for(1, seen);
    checks++;
    if (!seen || bus_if.chk_pos_i !== 5'(m_i + 1)) begin
      errors++; $display("FAIL edge_gravity_chk: seen=%b i=%0d, want i=%0d", seen, bus_if.chk_pos_i, m_i + 1);
    end
    ack_chk(1'b0);
    wait_for(2, seen);
    hold = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus_if.lock_req) hold++;
    end
    checks++;
    if (!seen || hold != 2 || cur_pos_i !== 5'(m_i)) begin
      errors++; $display("FAIL edge_lock_hold: seen=%b hold=%0d i=%0d, want seen=1 hold=2 i=%0d", seen, hold, cur_pos_i, m_i);
    end
    ack_lock();
    checks++;
    if (bus_if.lock_req !== 1'b0 || bus_if.gen_enable !== 1'b1 || piece_valid !== 1'b0) begin
      errors++; $display("FAIL edge_after_lock: lock=%b gen=%b pv=%b, want 0 1 0", bus_if.lock_req, bus_if.gen_enable, piece_valid);
    end
  endtask

  task automatic test_blocked_spawn();
    bit seen, bad;
    give_gen(0, 4, 2);
    checks++;
    if ({bus_if.chk_req, bus_if.chk_pos_i, bus_if.chk_pos_j, bus_if.chk_rot, bus_if.chk_type} !== {1'b1, 5'd0, 5'd4, 2'd0, 3'd2}) begin
      errors++; $display("FAIL blocked_payload: chk=%b %0d,%0d r%0d t%0d, want 1 0,4 r0 t2",
                         bus_if.chk_req, bus_if.chk_pos_i, bus_if.chk_pos_j, bus_if.chk_rot, bus_if.chk_type);
    end
    ack_chk(1'b0);
    checks++;
    if ({game_over, piece_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL blocked_over: go=%b pv=%b busy=%b, want 1 0 0", game_over, piece_valid, busy);
    end
    btn_drop = 1'b1; gravity_tick = 1'b1; btn_rot = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      btn_drop = 1'b0; gravity_tick = 1'b0; btn_rot = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      if (bus_if.gen_enable || bus_if.chk_req || bus_if.lock_req || !game_over) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL over_quiet: request or game_over drop seen in OVER, want none"); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (bus_if.gen_enable !== 1'b1 || game_over !== 1'b0) begin
      errors++; $display("FAIL restart: gen=%b go=%b, want 1 0", bus_if.gen_enable, game_over);
    end
    give_gen(0, 4, 5);
    wait_for(1, seen);
    ack_chk(1'b1);
    m_i = 0; m_j = 4; m_rot = 0; m_type = 5;
    checks++;
    if (!seen || {cur_pos_i, cur_pos_j, cur_type, piece_valid} !== {5'd0, 5'd4, 3'd5, 1'b1}) begin
      errors++; $display("FAIL restart_spawn: %0d,%0d t%0d pv=%b, want 0,4 t5 pv=1", cur_pos_i, cur_pos_j, cur_type, piece_valid);
    end
  endtask

  task automatic test_hard_drop();
    bit seen, ok;
    for (int k = 0; k < 2; k++) begin
      pulse(1);
      wait_for(1, seen);
      ack_chk(1'b1);
      m_i++;
    end
    checks++;
    if (cur_pos_i !== 5'd2) begin errors++; $display("FAIL drop_setup: i=%0d, want 2", cur_pos_i); end
    pulse(0);
`ifdef TETRIS_HARD_DROP_EN
    ok = 1'b1;
    while (ok) begin
      wait_for(1, seen);
      checks++;
      if (!seen || bus_if.chk_pos_i !== 5'(m_i + 1)) begin
        errors++; $display("FAIL drop_step: seen=%b i=%0d, want i=%0d", seen, bus_if.chk_pos_i, m_i + 1);
      end
      ok = seen && (m_i + 1 < 6);
      ack_chk(ok);
      if (ok) m_i++;
      checks++;
      if (bus_if.chk_req !== 1'b0) begin errors++; $display("FAIL drop_req_gap: chk_req=%b after ack, want 0", bus_if.chk_req); end
    end
    wait_for(2, seen);
    checks++;
    if (!seen || cur_pos_i !== 5'd5) begin
      errors++; $display("FAIL hard_drop_lock: lock=%b i=%0d, want lock=1 i=5", seen, cur_pos_i);
    end
    ack_lock();
    wait_for(0, seen);
    give_gen(0, 4, 5);
    wait_for(1, seen);
    ack_chk(1'b1);
    m_i = 0; m_j = 4; m_rot = 0; m_type = 5;
`else
    wait_for(1, seen);
    ok = (m_i + 1 < 6);
    checks++;
    if (!seen || bus_if.chk_pos_i !== 5'd3) begin
      errors++; $display("FAIL drop_single_chk: seen=%b i=%0d, want i=3", seen, bus_if.chk_pos_i);
    end
    ack_chk(ok);
    m_i++;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus_if.chk_req || bus_if.lock_req) seen = 1'b1;
    end
    checks++;
    if (seen || cur_pos_i !== 5'd3) begin
      errors++; $display("FAIL drop_as_gravity: extra_req=%b i=%0d, want 0 and i=3", seen, cur_pos_i);
    end
`endif
  endtask

  task automatic test_random();
    bit seen, ok, done, need_lock, lock_seen, bad;
    int a, c_i, c_j, c_rot, gi, gj, gt;
    for (int it = 0; it < 80; it++) begin
      a = $urandom_range(0, 4);
      need_lock = 1'b0; lock_seen = 1'b0;
      pulse(a);
      if ((a == 3 && m_j == 0) || (a == 4 && m_j == 31)) begin
        bad = 1'b0;
        repeat (4) begin
          @(negedge clk);
          if (bus_if.chk_req || busy) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL rnd_discard it=%0d: activity at wall j=%0d, want none", it, m_j); end
      end else if (a <= 1 && m_i == 31) begin
        bad = 1'b0; seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (bus_if.chk_req) bad = 1'b1;
          if (bus_if.lock_req) begin seen = 1'b1; break; end
        end
        checks++;
        if (bad || !seen) begin
          errors++; $display("FAIL rnd_bottom_lock it=%0d: chk=%b lock=%b, want chk=0 lock=1", it, bad, seen);
        end
        need_lock = 1'b1; lock_seen = 1'b1;
      end else begin
        done = 1'b0;
        while (!done) begin
          c_i   = (a <= 1) ? m_i + 1 : m_i;
          c_j   = (a == 3) ? m_j - 1 : (a == 4) ? m_j + 1 : m_j;
          c_rot = (a == 2) ? (m_rot + 1) % 4 : m_rot;
          wait_for(1, seen);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          checks++;
          if (!seen || bus_if.chk_req !== 1'b1 ||
              {bus_if.chk_pos_i, bus_if.chk_pos_j, bus_if.chk_rot, bus_if.chk_type} !== {5'(c_i), 5'(c_j), 2'(c_rot), 3'(m_type)}) begin
            errors++; $display("FAIL rnd_chk it=%0d a=%0d: got %0d,%0d r%0d t%0d req=%b, want %0d,%0d r%0d t%0d",
                               it, a, bus_if.chk_pos_i, bus_if.chk_pos_j, bus_if.chk_rot, bus_if.chk_type, bus_if.chk_req,
                               c_i, c_j, c_rot, m_type);
          end
          ok = ($urandom_range(0, 3) != 0);
          ack_chk(ok);
          if (ok) begin m_i = c_i; m_j = c_j; m_rot = c_rot; end
          done = 1'b1;
          if (!ok && a <= 1) need_lock = 1'b1;
`ifdef TETRIS_HARD_DROP_EN
          if (ok && a == 0) begin
            if (m_i == 31) need_lock = 1'b1;
            else done = 1'b0;
          end
`endif
          if (!seen) done = 1'b1;
        end
      end
      if (need_lock) begin
        if (!lock_seen) begin
          wait_for(2, seen);
          checks++;
          if (!seen) begin errors++; $display("FAIL rnd_lock it=%0d: lock_req not seen, want 1", it); end
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        ack_lock();
        wait_for(0, seen);
        gi = ($urandom_range(0, 1) != 0) ? $urandom_range(26, 31) : $urandom_range(0, 31);
        gj = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 31 : 0) : $urandom_range(0, 31);
        gt = $urandom_range(0, 7);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        give_gen(gi, gj, gt);
        wait_for(1, seen);
        checks++;
        if (!seen || {bus_if.chk_pos_i, bus_if.chk_pos_j, bus_if.chk_rot, bus_if.chk_type} !== {5'(gi), 5'(gj), 2'd0, 3'(gt)}) begin
          errors++; $display("FAIL rnd_spawn it=%0d: got %0d,%0d r%0d t%0d, want %0d,%0d r0 t%0d",
                             it, bus_if.chk_pos_i, bus_if.chk_pos_j, bus_if.chk_rot, bus_if.chk_type, gi, gj, gt);
        end
        ack_chk(1'b1);
        m_i = gi; m_j = gj; m_rot = 0; m_type = gt;
      end
      @(negedge clk);
      checks++;
      if ({cur_pos_i, cur_pos_j, cur_rot, cur_type, piece_valid, busy} !==
          {5'(m_i), 5'(m_j), 2'(m_rot), 3'(m_type), 1'b1, 1'b0}) begin
        errors++; $display("FAIL rnd_state it=%0d a=%0d: got %0d,%0d r%0d t%0d pv=%b busy=%b, want %0d,%0d r%0d t%0d pv=1 busy=0",
                           it, a, cur_pos_i, cur_pos_j, cur_rot, cur_type, piece_valid, busy, m_i, m_j, m_rot, m_type);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen, bad;
    pulse(2);
    wait_for(1, seen);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || {bus_if.chk_req, busy, bus_if.gen_enable, bus_if.lock_req, piece_valid} !== 5'd0) begin
      errors++; $display("FAIL reset_mid_chk: seen=%b chk=%b busy=%b gen=%b lock=%b pv=%b, want seen=1 rest 0",
                         seen, bus_if.chk_req, busy, bus_if.gen_enable, bus_if.lock_req, piece_valid);
    end
    @(negedge clk);
    bus_if.chk_ack = 1'b1; bus_if.chk_ok = 1'b1; bus_if.lock_ack = 1'b1; bus_if.gen_done = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy || bus_if.chk_req || bus_if.gen_enable || bus_if.lock_req || piece_valid) bad = 1'b1;
    end
    bus_if.chk_ack = 1'b0; bus_if.chk_ok = 1'b0; bus_if.lock_ack = 1'b0; bus_if.gen_done = 1'b0;
    checks++;
    if (bad || cur_pos_i !== 5'd0) begin
      errors++; $display("FAIL reset_late_acks: activity=%b i=%0d, want 0 and 0", bad, cur_pos_i);
    end
  endtask

  initial begin
    bus_if.gen_done = 1'b0; bus_if.gen_pos_i = 5'd0; bus_if.gen_pos_j = 5'd0; bus_if.gen_type = 3'd0;
    bus_if.chk_ack = 1'b0; bus_if.chk_ok = 1'b0; bus_if.lock_ack = 1'b0;
    m_i = 0; m_j = 0; m_rot = 0; m_type = 0;
    test_reset();
    test_spawn();
    test_priority();
    test_left_edge();
    test_blocked_spawn();
    test_hard_drop();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tetris_step_sched.md
TETRIS_STEP_SCHED -- requirements
Module: tetris_step_sched

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: start in 1 begin/restart game; gravity_tick in 1 one-cycle gravity pulse; btn_left, btn_right, btn_rot, btn_drop in 1 each, one-cycle user pulses.
REQ-003 SHALL have ports: gen_enable out 1 spawn request to piece generator; gen_done in 1 generator done; gen_pos_i, gen_pos_j in 5 spawn position; gen_type in 3 spawn piece type.
REQ-004 SHALL have ports: chk_req out 1 collision-check request; chk_pos_i, chk_pos_j out 5 candidate position; chk_rot out 2 candidate rotation; chk_type out 3 candidate piece type; chk_ack in 1 check done; chk_ok in 1 candidate fits, valid only with chk_ack.
REQ-005 SHALL have ports: lock_req out 1 write piece to board and clear lines; lock_ack in 1 lock done.
REQ-006 SHALL have ports: cur_pos_i, cur_pos_j out 5; cur_rot out 2; cur_type out 3 committed active piece; piece_valid out 1; game_over out 1; busy out 1 high in any state except READY, IDLE and OVER.

Function
REQ-007 SHALL implement states IDLE, SPAWN, SPAWN_CHK, READY, MOVE_CHK, LOCK, OVER.
REQ-008 IDLE or OVER with start=1 SHALL go to SPAWN next cycle and clear game_over; start SHALL be ignored in all other states.
REQ-009 SPAWN SHALL hold gen_enable=1 until the gen_done=1 cycle, then capture gen_pos_i/j and gen_type, set rot=0, and go to SPAWN_CHK.
REQ-010 chk_req SHALL stay high with stable payload until the chk_ack=1 cycle; chk_ok SHALL be sampled on that edge; chk_req SHALL be low the following cycle.
REQ-011 SPAWN_CHK with chk_ok=1 SHALL commit the piece to cur_*, set piece_valid=1, and go to READY; with chk_ok=0 it SHALL go to OVER with game_over=1 and piece_valid=0.
REQ-012 Each request pulse SHALL set a pending bit in any state except IDLE and OVER; entering SPAWN SHALL clear all pending bits; if a pulse arrives in the same cycle as its bit is cleared, set SHALL win.
REQ-013 READY SHALL serve one pending request per visit, priority drop > gravity > rot > left > right, clearing that bit when it goes to MOVE_CHK.
REQ-014 Candidates: gravity/down pos_i+1; left pos_j-1; right pos_j+1; rot (cur_rot+1) mod 4; type unchanged.
REQ-015 Left at pos_j=0 and right at pos_j=31 SHALL be discarded locally without chk_req; down at pos_i=31 SHALL go directly to LOCK.
REQ-016 MOVE_CHK with chk_ok=1 SHALL commit the candidate and return to READY; with chk_ok=0, a down move SHALL go to LOCK and any other move SHALL return to READY unchanged.
REQ-017 LOCK SHALL hold lock_req=1 until the lock_ack=1 cycle, then set piece_valid=0 and go to SPAWN.
REQ-018 OVER SHALL hold game_over=1 and issue no gen/chk/lock requests.

Reset
REQ-019 With rst_n=0, the state SHALL be IDLE and all outputs 0 (cur_*, piece_valid, game_over, busy, gen_enable, chk_req, lock_req), with pending bits cleared, asynchronously.
REQ-020 Reset mid-handshake SHALL drop gen_enable, chk_req and lock_req immediately; late ack/done inputs seen in IDLE SHALL be ignored.

Configuration
REQ-021 With TETRIS_HARD_DROP_EN defined, a served drop SHALL repeat down checks back-to-back, committing each success, until a failure or pos_i=31, then go to LOCK; without the macro, drop SHALL behave exactly as one gravity step.

Verification
REQ-022 Spawn: start=1, gen_done after 3 cycles with pos (0,4) type 5, chk_ok=1 -> cur=(0,4) rot 0 type 5, piece_valid=1, gen_enable high exactly until done.
REQ-023 Blocked spawn: chk_ok=0 on SPAWN_CHK -> game_over=1, piece_valid=0; a following start=1 -> SPAWN, game_over=0.
REQ-024 Priority: btn_left and gravity_tick in the same cycle while busy -> gravity checked first (pos_i+1), then left (pos_j-1).
REQ-025 Edge: cur_pos_j=0, btn_left -> no chk_req, state unchanged; gravity chk_ok=0 -> lock_req until lock_ack, then new gen_enable.
REQ-026 Hard drop (macro on): piece at pos_i=2, checker fails at row 6 -> cur_pos_i=5 then LOCK; macro off -> cur_pos_i=3 only.
REQ-027 Reset asserted with chk_req high -> chk_req=0 with no clock edge, state IDLE.
